// File: rtl/mmult_host.sv
// Host-side controller for the 3x3 matrix multiplier: collects 18 operand bytes,
// runs one mmult job under a timeout, then streams the nine 17-bit results out.
module mmult_host #(
    parameter int TIMEOUT = 1024
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mm_enable,
    output logic [71:0]   mm_A,
    output logic [71:0]   mm_B,
    input  logic          mm_valid,
    input  logic [152:0]  mm_C,
    output logic          out_valid,
    output logic [16:0]   out_data,
    output logic          out_last,
    input  logic          out_ready,
    output logic          done,
    output logic          err
);

    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_SEND} state_t;

    state_t          state_q, state_d;
    logic [7:0]      byte_q [18];
    logic [4:0]      cnt_q;
    logic [3:0]      idx_q;
    logic [TW-1:0]   tmo_q;
    logic [152:0]    c_q;
    logic            done_q;
    logic            err_q;
    logic [16:0]     c_ent [9];
    logic            run_tmo;
    logic            send_fire;

    assign run_tmo   = (state_q == S_RUN) && !mm_valid && (tmo_q == TMO_LAST);
    assign send_fire = (state_q == S_SEND) && out_ready;

    // Bytes 0..8 form A and 9..17 form B, entry 0 in the most significant slot.
    genvar gi;
    generate
        for (gi = 0; gi < 9; gi++) begin : g_pack
            assign mm_A[71-8*gi -: 8] = byte_q[gi];
            assign mm_B[71-8*gi -: 8] = byte_q[gi+9];
            assign c_ent[gi]          = c_q[152-17*gi -: 17];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset_n) state_q <= S_LOAD;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:  if (in_valid && cnt_q == 5'd17) state_d = S_RUN;
            S_RUN:   if (mm_valid)                   state_d = S_SEND;
                     else if (tmo_q == TMO_LAST)     state_d = S_LOAD;
            S_SEND:  if (out_ready && idx_q == 4'd8) state_d = S_LOAD;
            default:                                 state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < 18; i++) byte_q[i] <= '0;
            cnt_q  <= '0;
            idx_q  <= '0;
            tmo_q  <= '0;
            c_q    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= send_fire && (idx_q == 4'd8);
            err_q  <= run_tmo;
            case (state_q)
                S_LOAD: begin
                    // Holding the timeout at zero here guarantees a fresh budget on RUN entry.
                    tmo_q <= '0;
                    if (in_valid) begin
                        byte_q[cnt_q] <= in_data;
                        cnt_q         <= (cnt_q == 5'd17) ? 5'd0 : cnt_q + 5'd1;
                    end
                end
                S_RUN: begin
                    tmo_q <= tmo_q + 1'b1;
                    if (mm_valid) c_q <= mm_C;
                end
                S_SEND: begin
                    if (out_ready) idx_q <= (idx_q == 4'd8) ? 4'd0 : idx_q + 4'd1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == S_LOAD);
        mm_enable = (state_q == S_RUN);
        out_valid = (state_q == S_SEND);
        out_data  = (state_q == S_SEND) ? c_ent[idx_q] : 17'd0;
        out_last  = (state_q == S_SEND) && (idx_q == 4'd8);
        done      = done_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_mmult_host.sv
// Directed bench for mmult_host against a behavioural mmult stub with fixed latency.
module tb_mmult_host;

    logic          clk = 1'b0;
    logic          reset_n, in_valid, in_ready, mm_enable, mm_valid;
    logic [7:0]    in_data;
    logic [71:0]   mm_A, mm_B;
    logic [152:0]  mm_C;
    logic          out_valid, out_last, out_ready, done, err;
    logic [16:0]   out_data;

    logic          st_valid = 1'b0;
    logic [152:0]  st_C = '0;
    int            st_cnt = 0;
    logic          stub_never;
    logic          glitch;

    int checks = 0;
    int errors = 0;

    localparam logic [71:0] A1 = 72'h0E5E03391D02003108;
    localparam logic [71:0] B1 = 72'h0A09071D0502012809;
    logic [16:0] exp1 [9] = '{17'd2869, 17'd716, 17'd313, 17'd1413, 17'd738,
                              17'd475, 17'd1429, 17'd565, 17'd170};
    logic [16:0] exp0 [9] = '{default: 17'd0};

    always #5 clk = ~clk;

    mmult_host #(.TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mm_enable(mm_enable), .mm_A(mm_A), .mm_B(mm_B),
        .mm_valid(mm_valid), .mm_C(mm_C),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .done(done), .err(err)
    );

    function automatic logic [152:0] mmul(input logic [71:0] a, input logic [71:0] b);
        logic [152:0] c;
        c = '0;
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                int s;
                s = 0;
                for (int k = 0; k < 3; k++)
                    s = s + int'(a[71-8*(3*i+k) -: 8]) * int'(b[71-8*(3*k+j) -: 8]);
                c[152-17*(3*i+j) -: 17] = 17'(s);
            end
        return c;
    endfunction

    // mmult stand-in: valid rises five enabled cycles after enable, holds until enable drops.
    always @(posedge clk) begin
        if (!mm_enable) begin
            st_cnt   <= 0;
            st_valid <= 1'b0;
        end else begin
            st_cnt <= st_cnt + 1;
            if (!stub_never && st_cnt == 4) begin
                st_valid <= 1'b1;
                st_C     <= mmul(mm_A, mm_B);
            end
        end
    end

    assign mm_valid = st_valid | glitch;
    assign mm_C     = glitch ? {9{17'h1ABCD}} : st_C;

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic load(input logic [71:0] a, input logic [71:0] b, input bit toggle,
                        output int idle_en);
        idle_en = 0;
        for (int i = 0; i < 18; i++) begin
            if (toggle) begin
                @(negedge clk);
                in_valid = 1'b0;
                if (!mm_enable) idle_en++;
            end
            @(negedge clk);
            if (!mm_enable) idle_en++;
            if (i == 0 || i == 17) check("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = (i < 9) ? a[71-8*i -: 8] : b[71-8*(i-9) -: 8];
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("en_rise", mm_enable, 1);
        $display("load A=%h B=%h", mm_A, mm_B);
    endtask

    task automatic wait_valid();
        int cyc;
        cyc = 0;
        while (!mm_valid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("mm_valid_seen", mm_valid, 1);
        @(negedge clk);
        check("first_out_valid", out_valid, 1);
        check("en_fall", mm_enable, 0);
    endtask

    task automatic recv(input logic [16:0] e [9], input int stall_at, input int first,
                        input int stop);
        int got, stall, cyc;
        got = first; stall = 0; cyc = 0;
        while (got < stop && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (!out_valid) begin
                out_ready = 1'b1;
                continue;
            end
            if (got == stall_at && stall < 3) begin
                out_ready = 1'b0;
                stall++;
                check("stall_hold", out_data, e[got]);
            end else begin
                out_ready = 1'b1;
                check($sformatf("beat%0d", got), out_data, e[got]);
                check("last", out_last, (got == 8));
                $display("beat %0d data %0d last %0b", got, out_data, out_last);
                got++;
            end
        end
        check("recv_count", got, stop);
        @(negedge clk);
        out_ready = 1'b0;
        if (stop == 9) begin
            check("done_pulse", done, 1);
            check("ov_after", out_valid, 0);
            check("in_ready_after", in_ready, 1);
            @(negedge clk);
            check("done_once", done, 0);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int gap, en_cnt, err_cnt, ov_cnt;
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        glitch = 1'b0; stub_never = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_en", mm_enable, 0);
        check("rst_ov", out_valid, 0);
        check("rst_od", out_data, 0);
        check("rst_last", out_last, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_A", mm_A, 0);
        reset_n = 1'b1;

        // Scenario 1: reference job
        load(A1, B1, 0, gap);
        check("mm_A", mm_A, A1);
        check("mm_B", mm_B, B1);
        wait_valid();
        recv(exp1, -1, 0, 9);

        // Scenario 2: back-to-back with B = 0
        load(A1, 72'd0, 0, gap);
        check("gap18", (gap >= 18), 1);
        check("mm_B_zero", mm_B, 0);
        wait_valid();
        recv(exp0, -1, 0, 9);

        // Scenario 3: sparse input, output stall at beat 4
        load(A1, B1, 1, gap);
        check("mm_A_sparse", mm_A, A1);
        wait_valid();
        recv(exp1, 4, 0, 9);

        // Scenario 4: stub never answers
        stub_never = 1'b1;
        load(A1, B1, 0, gap);
        en_cnt = 0; err_cnt = 0; ov_cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (mm_enable) en_cnt++;
            if (err) err_cnt++;
            if (out_valid) ov_cnt++;
            @(negedge clk);
        end
        stub_never = 1'b0;
        check("tmo_en_cycles", en_cnt, 16);
        check("tmo_err_pulses", err_cnt, 1);
        check("tmo_no_out", ov_cnt, 0);
        check("tmo_in_ready", in_ready, 1);

        // Scenario 6a: mm_valid glitch while idle in LOAD
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        check("glitch_load_ready", in_ready, 1);
        check("glitch_load_en", mm_enable, 0);
        check("glitch_load_ov", out_valid, 0);

        // Scenario 5: reset during SEND at beat 3
        load(A1, B1, 0, gap);
        wait_valid();
        recv(exp1, -1, 0, 3);
        check("pre_reset", out_data, exp1[3]);
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        check("mid_rst_ov", out_valid, 0);
        check("mid_rst_ready", in_ready, 1);
        check("mid_rst_A", mm_A, 0);
        check("mid_rst_B", mm_B, 0);
        check("mid_rst_done", done, 0);
        @(negedge clk);
        check("mid_rst_done2", done, 0);
        load(A1, B1, 0, gap);
        wait_valid();
        recv(exp1, -1, 0, 9);

        // Scenario 6b: mm_valid glitch while stalled in SEND
        load(A1, B1, 0, gap);
        wait_valid();
        recv(exp1, -1, 0, 2);
        glitch = 1'b1;
        @(negedge clk);
        glitch = 1'b0;
        check("glitch_send_ov", out_valid, 1);
        check("glitch_send_data", out_data, exp1[2]);
        @(negedge clk);
        check("glitch_send_data2", out_data, exp1[2]);
        recv(exp1, -1, 2, 9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
